// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding and frame sizing.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    function automatic int frame_cycles(input int clks_per_bit, input int data_bits,
                                        input int parity, input int stop_bits);
        return (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Producer-side bundle of the buffered UART transmitter; parameters must match the attached transmitter.
interface uart_tx_frame_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    logic                        i_TX_DV;
    logic [DATA_BITS-1:0]        i_TX_Byte;
    logic                        o_TX_Ready;
    logic                        o_Overflow;
    logic [$clog2(FIFO_DEPTH):0] o_FIFO_Count;
    logic                        o_TX_Active;
    logic                        o_TX_Serial;
    logic                        o_TX_Done;

    modport master (
        output i_TX_DV, i_TX_Byte,
        input  o_TX_Ready, o_Overflow, o_FIFO_Count, o_TX_Active, o_TX_Serial, o_TX_Done
    );

    modport slave (
        input  i_TX_DV, i_TX_Byte,
        output o_TX_Ready, o_Overflow, o_FIFO_Count, o_TX_Active, o_TX_Serial, o_TX_Done
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head word visible combinationally, pop takes effect on the edge.
// Writes while full are dropped and flagged by a one-cycle overflow pulse, even when a pop coincides.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_vld,
    input  logic [WIDTH-1:0]       wr_dat,
    output logic                   wr_rdy,
    output logic                   rd_vld,
    input  logic                   rd_rdy,
    output logic [WIDTH-1:0]       rd_dat,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign wr_rdy = (count != (AW+1)'(DEPTH));
    assign rd_vld = (count != '0);
    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_rdy && rd_vld;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= wr_vld && !wr_rdy;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// Buffered UART transmitter: FIFO-fed serialiser with configurable data width, parity and stop bits.
// Line falls two edges after a write into an empty idle block; queued words chain with zero idle gap.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic           i_Clock,
    input  logic           i_Reset,
    uart_tx_frame_if.slave tx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DONE_AT   = CW'(CLKS_PER_BIT - 2);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
    localparam logic          PAR_SEED  = (PARITY == PAR_ODD);

    tx_state_t            state;
    logic [CW-1:0]        clk_cnt;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_acc;
    logic                 serial;
    logic                 active;
    logic                 done;
    logic                 head_vld;
    logic [DATA_BITS-1:0] head;
    logic                 pop;
    logic                 bit_end;
    logic                 frame_end;

    assign bit_end   = (clk_cnt == BIT_LAST);
    assign frame_end = (state == ST_STOP) && bit_end && (bit_idx == STOP_LAST);
    assign pop       = head_vld && ((state == ST_IDLE) || frame_end);

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (i_Clock),
        .rst      (i_Reset),
        .wr_vld   (tx.i_TX_DV),
        .wr_dat   (tx.i_TX_Byte),
        .wr_rdy   (tx.o_TX_Ready),
        .rd_vld   (head_vld),
        .rd_rdy   (pop),
        .rd_dat   (head),
        .count    (tx.o_FIFO_Count),
        .overflow (tx.o_Overflow)
    );

    // serial is loaded with the next bit on each boundary edge, so it stays registered.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state   <= ST_IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_acc <= 1'b0;
            serial  <= 1'b1;
            active  <= 1'b0;
            done    <= 1'b0;
        end else begin
            done    <= (state == ST_STOP) && (bit_idx == STOP_LAST) && (clk_cnt == DONE_AT);
            clk_cnt <= (state == ST_IDLE || bit_end) ? '0 : clk_cnt + 1'b1;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        shreg   <= head;
                        par_acc <= PAR_SEED;
                        serial  <= 1'b0;
                        active  <= 1'b1;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        serial  <= shreg[0];
                        bit_idx <= '0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shreg   <= shreg >> 1;
                        par_acc <= par_acc ^ shreg[0];
                        if (bit_idx == DATA_LAST) begin
                            bit_idx <= '0;
                            if (PARITY != PAR_NONE) begin
                                serial <= par_acc ^ shreg[0];
                                state  <= ST_PARITY;
                            end else begin
                                serial <= 1'b1;
                                state  <= ST_STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            serial  <= shreg[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        serial <= 1'b1;
                        state  <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (frame_end) begin
                        bit_idx <= '0;
                        if (pop) begin
                            shreg   <= head;
                            par_acc <= PAR_SEED;
                            serial  <= 1'b0;
                            state   <= ST_START;
                        end else begin
                            active <= 1'b0;
                            state  <= ST_IDLE;
                        end
                    end else if (bit_end) begin
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign tx.o_TX_Serial = serial;
    assign tx.o_TX_Active = active;
    assign tx.o_TX_Done   = done;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three parameter sets, frames compared cycle by cycle against a bit-level frame model.
module tb_uart_tx_frame;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    uart_tx_frame_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if_a ();
    uart_tx_frame_if #(.DATA_BITS(8), .FIFO_DEPTH(4))  if_b ();
    uart_tx_frame_if #(.DATA_BITS(7), .FIFO_DEPTH(2))  if_c ();

    uart_tx_frame #(.CLKS_PER_BIT(217), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16))
        dut_a (.i_Clock(clk), .i_Reset(rst_a), .tx(if_a));
    uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
        dut_b (.i_Clock(clk), .i_Reset(rst_b), .tx(if_b));
    uart_tx_frame #(.CLKS_PER_BIT(3), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(2))
        dut_c (.i_Clock(clk), .i_Reset(rst_c), .tx(if_c));

    function automatic int p_cpb(input int s);
        case (s) 0: return 217; 1: return 4; default: return 3; endcase
    endfunction
    function automatic int p_db(input int s);
        case (s) 0: return 8; 1: return 8; default: return 7; endcase
    endfunction
    function automatic int p_par(input int s);
        case (s) 0: return 0; 1: return 1; default: return 2; endcase
    endfunction
    function automatic int p_stop(input int s);
        case (s) 0: return 1; 1: return 1; default: return 2; endcase
    endfunction
    function automatic int p_depth(input int s);
        case (s) 0: return 16; 1: return 4; default: return 2; endcase
    endfunction
    function automatic int f_len(input int s);
        return (1 + p_db(s) + ((p_par(s) != 0) ? 1 : 0) + p_stop(s)) * p_cpb(s);
    endfunction

    // Reference frame: start 0, data LSB first, optional parity, then stop ones.
    function automatic logic exp_bit(input int s, input logic [8:0] w, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= p_db(s)) return w[idx-1];
        if (p_par(s) != 0 && idx == p_db(s) + 1) return (p_par(s) == 1) ? ~(^w) : ^w;
        return 1'b1;
    endfunction

    function automatic logic [8:0] rnd_word(input int s);
        return 9'($urandom_range(0, (1 << p_db(s)) - 1));
    endfunction

    function automatic logic ser_of(input int s);
        case (s) 0: return if_a.o_TX_Serial; 1: return if_b.o_TX_Serial; default: return if_c.o_TX_Serial; endcase
    endfunction
    function automatic logic act_of(input int s);
        case (s) 0: return if_a.o_TX_Active; 1: return if_b.o_TX_Active; default: return if_c.o_TX_Active; endcase
    endfunction
    function automatic logic done_of(input int s);
        case (s) 0: return if_a.o_TX_Done; 1: return if_b.o_TX_Done; default: return if_c.o_TX_Done; endcase
    endfunction
    function automatic logic rdy_of(input int s);
        case (s) 0: return if_a.o_TX_Ready; 1: return if_b.o_TX_Ready; default: return if_c.o_TX_Ready; endcase
    endfunction
    function automatic logic ovf_of(input int s);
        case (s) 0: return if_a.o_Overflow; 1: return if_b.o_Overflow; default: return if_c.o_Overflow; endcase
    endfunction
    function automatic int cnt_of(input int s);
        case (s)
            0: return int'(if_a.o_FIFO_Count);
            1: return int'(if_b.o_FIFO_Count);
            default: return int'(if_c.o_FIFO_Count);
        endcase
    endfunction

    task automatic drv(input int s, input logic dv, input logic [8:0] w);
        case (s)
            0: begin if_a.i_TX_DV = dv; if_a.i_TX_Byte = w[7:0]; end
            1: begin if_b.i_TX_DV = dv; if_b.i_TX_Byte = w[7:0]; end
            default: begin if_c.i_TX_DV = dv; if_c.i_TX_Byte = w[6:0]; end
        endcase
    endtask

    task automatic put(input int s, input logic [8:0] w);
        drv(s, 1'b1, w);
        @(posedge clk);
        #1;
        drv(s, 1'b0, 9'h0);
    endtask

    // Waits for a start bit, then compares every cycle of one frame with the model.
    task automatic check_frame(input int s, input logic [8:0] w, input string nm, output int gap);
        int cpb, len, ok, dn_cnt, dn_at, act_cnt;
        cpb = p_cpb(s);
        len = f_len(s);
        gap = 0;
        @(negedge clk);
        while (ser_of(s) !== 1'b0 && gap < 4 * len) begin
            @(negedge clk);
            gap++;
        end
        checks++;
        if (ser_of(s) !== 1'b0) begin
            errors++;
            $display("FAIL %s start: line %b after %0d cycles, required 0", nm, ser_of(s), gap);
            return;
        end
        ok = 0; dn_cnt = 0; dn_at = -1; act_cnt = 0;
        for (int c = 0; c < len; c++) begin
            if (c != 0) @(negedge clk);
            if (ser_of(s) === exp_bit(s, w, c / cpb)) ok++;
            if (act_of(s) === 1'b1) act_cnt++;
            if (done_of(s) === 1'b1) begin dn_cnt++; dn_at = c; end
            if (c % cpb == cpb - 1) begin
                checks++;
                if (ok !== cpb) begin
                    errors++;
                    $display("FAIL %s bit %0d word %h: %0d of %0d cycles at expected level %b",
                             nm, c / cpb, w, ok, cpb, exp_bit(s, w, c / cpb));
                end
                ok = 0;
            end
        end
        checks++;
        if (act_cnt !== len) begin
            errors++;
            $display("FAIL %s active: high %0d cycles, required %0d", nm, act_cnt, len);
        end
        checks++;
        if (dn_cnt !== 1 || dn_at !== len - 1) begin
            errors++;
            $display("FAIL %s done: %0d pulses last at cycle %0d, required 1 at %0d", nm, dn_cnt, dn_at, len - 1);
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            checks++; if (ser_of(s) !== 1'b1) begin errors++; $display("FAIL reset_serial dut%0d: %b, required 1", s, ser_of(s)); end
            checks++; if (act_of(s) !== 1'b0) begin errors++; $display("FAIL reset_active dut%0d: %b, required 0", s, act_of(s)); end
            checks++; if (done_of(s) !== 1'b0) begin errors++; $display("FAIL reset_done dut%0d: %b, required 0", s, done_of(s)); end
            checks++; if (ovf_of(s) !== 1'b0) begin errors++; $display("FAIL reset_overflow dut%0d: %b, required 0", s, ovf_of(s)); end
            checks++; if (rdy_of(s) !== 1'b1) begin errors++; $display("FAIL reset_ready dut%0d: %b, required 1", s, rdy_of(s)); end
            checks++; if (cnt_of(s) !== 0) begin errors++; $display("FAIL reset_count dut%0d: %0d, required 0", s, cnt_of(s)); end
        end
    endtask

    task automatic test_single(input int s, input logic [8:0] w, input string nm);
        int gap;
        put(s, w);
        @(negedge clk);
        checks++; if (cnt_of(s) !== 1) begin errors++; $display("FAIL %s lat_count: %0d, required 1", nm, cnt_of(s)); end
        checks++; if (ser_of(s) !== 1'b1 || act_of(s) !== 1'b0) begin
            errors++; $display("FAIL %s lat_idle: serial %b active %b, required 1 0", nm, ser_of(s), act_of(s));
        end
        check_frame(s, w, nm, gap);
        checks++; if (gap !== 0) begin errors++; $display("FAIL %s lat_start: gap %0d, required 0", nm, gap); end
        @(negedge clk);
        checks++; if (act_of(s) !== 1'b0 || ser_of(s) !== 1'b1) begin
            errors++; $display("FAIL %s idle_after: active %b serial %b, required 0 1", nm, act_of(s), ser_of(s));
        end
    endtask

    task automatic test_back_to_back();
        int gap;
        drv(1, 1'b1, 9'h000); @(posedge clk); #1;
        drv(1, 1'b1, 9'h0FF); @(posedge clk); #1;
        drv(1, 1'b0, 9'h0);
        check_frame(1, 9'h000, "b2b_first", gap);
        check_frame(1, 9'h0FF, "b2b_second", gap);
        checks++; if (gap !== 0) begin errors++; $display("FAIL b2b_gap: %0d idle cycles, required 0", gap); end
        @(negedge clk);
        checks++; if (act_of(1) !== 1'b0) begin errors++; $display("FAIL b2b_active_fall: %b, required 0", act_of(1)); end
    endtask

    task automatic test_overflow();
        logic [8:0] w [6];
        int exp_cnt [6];
        int ovf_cnt, gap, bad;
        exp_cnt = '{1, 1, 2, 3, 4, 4};
        for (int i = 0; i < 6; i++) w[i] = rnd_word(1);
        ovf_cnt = 0;
        fork
            begin
                drv(1, 1'b1, w[0]);
                for (int i = 0; i < 6; i++) begin
                    @(posedge clk); #1;
                    if (i < 5) drv(1, 1'b1, w[i+1]); else drv(1, 1'b0, 9'h0);
                    @(negedge clk);
                    checks++; if (cnt_of(1) !== exp_cnt[i]) begin
                        errors++; $display("FAIL ovf_count write %0d: %0d, required %0d", i, cnt_of(1), exp_cnt[i]);
                    end
                    checks++; if (rdy_of(1) !== (exp_cnt[i] < 4)) begin
                        errors++; $display("FAIL ovf_ready write %0d: %b, required %b", i, rdy_of(1), exp_cnt[i] < 4);
                    end
                    if (ovf_of(1) === 1'b1) ovf_cnt++;
                end
                repeat (3) begin @(negedge clk); if (ovf_of(1) === 1'b1) ovf_cnt++; end
                checks++; if (ovf_cnt !== 1) begin errors++; $display("FAIL ovf_pulse: %0d pulses, required 1", ovf_cnt); end
            end
            begin
                for (int i = 0; i < 5; i++) check_frame(1, w[i], "ovf_frame", gap);
            end
        join
        bad = 0;
        for (int c = 0; c < 2 * f_len(1); c++) begin
            @(negedge clk);
            if (ser_of(1) !== 1'b1 || done_of(1) !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL ovf_sixth_frame: %0d busy cycles, required 0", bad); end
        checks++; if (cnt_of(1) !== 0) begin errors++; $display("FAIL ovf_drain: count %0d, required 0", cnt_of(1)); end
    endtask

    task automatic test_reset_mid();
        logic [8:0] w;
        int n, bad, gap;
        drv(1, 1'b1, rnd_word(1)); @(posedge clk); #1;
        drv(1, 1'b1, rnd_word(1)); @(posedge clk); #1;
        drv(1, 1'b0, 9'h0);
        n = 0;
        while (ser_of(1) !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        checks++; if (ser_of(1) !== 1'b0) begin errors++; $display("FAIL rmid_start: line %b, required 0", ser_of(1)); end
        repeat (p_cpb(1) * 5) @(negedge clk);
        checks++; if (cnt_of(1) !== 1) begin errors++; $display("FAIL rmid_pre_count: %0d, required 1", cnt_of(1)); end
        rst_b = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0;
        @(negedge clk);
        checks++; if (ser_of(1) !== 1'b1) begin errors++; $display("FAIL rmid_serial: %b, required 1", ser_of(1)); end
        checks++; if (cnt_of(1) !== 0) begin errors++; $display("FAIL rmid_count: %0d, required 0", cnt_of(1)); end
        checks++; if (act_of(1) !== 1'b0) begin errors++; $display("FAIL rmid_active: %b, required 0", act_of(1)); end
        bad = 0;
        for (int c = 0; c < 2 * f_len(1); c++) begin
            if (ser_of(1) !== 1'b1 || done_of(1) !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rmid_quiet: %0d busy cycles, required 0", bad); end
        w = rnd_word(1);
        put(1, w);
        check_frame(1, w, "rmid_fresh", gap);
    endtask

    task automatic test_write_on_pop();
        logic [8:0] w0, w1, w2;
        int n, gap;
        w0 = rnd_word(1); w1 = rnd_word(1); w2 = rnd_word(1);
        fork
            begin
                drv(1, 1'b1, w0); @(posedge clk); #1;
                drv(1, 1'b1, w1); @(posedge clk); #1;
                drv(1, 1'b0, 9'h0);
                @(negedge clk);
                checks++; if (cnt_of(1) !== 1) begin errors++; $display("FAIL wop_idle_count: %0d, required 1", cnt_of(1)); end
                n = 0;
                while (done_of(1) !== 1'b1 && n < 4 * f_len(1)) begin @(negedge clk); n++; end
                checks++; if (done_of(1) !== 1'b1) begin errors++; $display("FAIL wop_done_wait: %b, required 1", done_of(1)); end
                put(1, w2);
                @(negedge clk);
                checks++; if (cnt_of(1) !== 1) begin errors++; $display("FAIL wop_stop_count: %0d, required 1", cnt_of(1)); end
            end
            begin
                check_frame(1, w0, "wop_frame0", gap);
                check_frame(1, w1, "wop_frame1", gap);
                checks++; if (gap !== 0) begin errors++; $display("FAIL wop_gap1: %0d, required 0", gap); end
                check_frame(1, w2, "wop_frame2", gap);
                checks++; if (gap !== 0) begin errors++; $display("FAIL wop_gap2: %0d, required 0", gap); end
            end
        join
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random(input int s);
        logic [8:0] q [$];
        int n, gap;
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, p_depth(s));
            q.delete();
            for (int i = 0; i < n; i++) q.push_back(rnd_word(s));
            fork
                begin
                    for (int i = 0; i < n; i++) begin drv(s, 1'b1, q[i]); @(posedge clk); #1; end
                    drv(s, 1'b0, 9'h0);
                end
                begin
                    for (int i = 0; i < n; i++) begin
                        check_frame(s, q[i], "random", gap);
                        if (i > 0) begin
                            checks++;
                            if (gap !== 0) begin errors++; $display("FAIL random_gap dut%0d frame %0d: %0d, required 0", s, i, gap); end
                        end
                    end
                end
            join
            repeat ($urandom_range(2, 6)) @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        drv(0, 1'b0, 9'h0); drv(1, 1'b0, 9'h0); drv(2, 1'b0, 9'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        @(negedge clk);
        test_reset();
        test_single(0, 9'h03F, "basic_8n1");
        test_single(2, 9'h055, "even_2stop");
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_write_on_pop();
        test_random(1);
        test_random(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
